// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Unsigned magnitude of an operand; -2^31 maps to 32'h8000_0000.
    function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v, input logic sgn);
        logic [DIV_W-1:0] res;
        if (sgn && v[DIV_W-1]) begin
            res = ~v + 32'd1;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, try to subtract.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem,
    input  logic             bit_in,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_next,
    output logic             q_bit
);

    logic [DIV_W-1:0] shifted_s;
    logic [DIV_W-1:0] diff_s;
    logic             ge_s;

    // The 33-bit partial remainder is {rem[31], shifted_s}. When its top bit
    // is set it already exceeds any divisor, and the true difference fits in
    // 32 bits, so a wrapped 32-bit subtraction gives the exact result.
    always_comb begin
        shifted_s = {rem[DIV_W-2:0], bit_in};
        diff_s    = shifted_s - divisor;
        ge_s      = rem[DIV_W-1] | (shifted_s >= divisor);
        if (ge_s) begin
            rem_next = diff_s;
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted_s;
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/bit32_divider.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per clock,
// start/done handshake with fixed 33-cycle latency.
module bit32_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divider,
    input  logic             s,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             error,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIV_W-1:0] dvd_q;       // dividend magnitude shifting out, quotient bits shifting in
    logic [DIV_W-1:0] dvs_q;       // divisor magnitude
    logic [DIV_W-1:0] rem_q;       // partial remainder
    logic [DIV_W-1:0] orig_q;      // original dividend, returned on divide-by-zero
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             zero_q;
    logic [DIV_W-1:0] quotient_q;
    logic [DIV_W-1:0] remainder_q;
    logic             error_q;
    logic             busy_q;
    logic             done_q;

    logic [DIV_W-1:0] rem_d;
    logic             q_bit_d;
    logic [DIV_W-1:0] quo_fix_d;
    logic [DIV_W-1:0] rem_fix_d;

    div_step u_step (
        .rem      (rem_q),
        .bit_in   (dvd_q[DIV_W-1]),
        .divisor  (dvs_q),
        .rem_next (rem_d),
        .q_bit    (q_bit_d)
    );

    // Sign fix-up of the magnitude results and the divide-by-zero override.
    always_comb begin
        quo_fix_d = dvd_q;
        rem_fix_d = rem_q;
        if (zero_q) begin
            quo_fix_d = {DIV_W{1'b1}};
            rem_fix_d = orig_q;
        end else begin
            if (neg_quo_q) begin
                quo_fix_d = ~dvd_q + 32'd1;
            end else begin
                quo_fix_d = dvd_q;
            end
            if (neg_rem_q) begin
                rem_fix_d = ~rem_q + 32'd1;
            end else begin
                rem_fix_d = rem_q;
            end
        end
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            dvd_q       <= 32'd0;
            dvs_q       <= 32'd0;
            rem_q       <= 32'd0;
            orig_q      <= 32'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q     <= mag(dividend, s);
                        dvs_q     <= mag(divider, s);
                        rem_q     <= 32'd0;
                        orig_q    <= dividend;
                        neg_quo_q <= s & (dividend[DIV_W-1] ^ divider[DIV_W-1]);
                        neg_rem_q <= s & dividend[DIV_W-1];
                        zero_q    <= (divider == 32'd0);
                        cnt_q     <= 6'd0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[DIV_W-2:0], q_bit_d};
                    if (cnt_q == 6'd31) begin
                        cnt_q   <= 6'd0;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end else begin
                        cnt_q   <= cnt_q + 6'd1;
                    end
                end
                FIN: begin
                    quotient_q  <= quo_fix_d;
                    remainder_q <= rem_fix_d;
                    error_q     <= zero_q;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= 6'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign error     = error_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bit32_divider.sv
// Directed-vector and reference-model bench for bit32_divider.
module tb_bit32_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divider = 32'd0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        error;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    bit32_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divider   (divider),
        .s         (s),
        .quotient  (quotient),
        .remainder (remainder),
        .error     (error),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Launch one operation; optionally re-pulse start (with other operands)
    // once the cycle counter reaches poke_at. Returns results and latency.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input int poke_at,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic e, output int lat);
        bit got;
        @(negedge clk);
        dividend = a;
        divider  = b;
        s        = sg;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divider  = 32'h0000_0003;
        s        = ~sg;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) begin
                got = 1'b1;
            end
            if (lat == poke_at) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        q = quotient;
        r = remainder;
        e = error;
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                    output logic [31:0] q, output logic [31:0] r, output logic e);
        longint la;
        longint lb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            e = 1'b1;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
            e = 1'b0;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q = lq[31:0];
            r = lr[31:0];
            e = 1'b0;
        end
    endfunction

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          lat;
        int          done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ee;

        vecs[0]  = '{32'd183,       32'd14,         1'b0, 32'd13,          32'd1,          1'b0};
        vecs[1]  = '{32'd1000,      32'd100,        1'b0, 32'd10,          32'd0,          1'b0};
        vecs[2]  = '{32'd1003,      32'd150,        1'b0, 32'd6,           32'd103,        1'b0};
        vecs[3]  = '{32'd467,       32'd13,         1'b0, 32'd35,          32'd12,         1'b0};
        vecs[4]  = '{32'd0,         32'd10,         1'b0, 32'd0,           32'd0,          1'b0};
        vecs[5]  = '{32'd1,         32'd0,          1'b0, 32'hFFFF_FFFF,   32'd1,          1'b1};
        vecs[6]  = '{32'd5,         32'd2,          1'b0, 32'd2,           32'd1,          1'b0};
        vecs[7]  = '{-32'sd892,     32'sd67,        1'b1, -32'sd13,        -32'sd21,       1'b0};
        vecs[8]  = '{32'sd60000,    -32'sd30,       1'b1, -32'sd2000,      32'd0,          1'b0};
        vecs[9]  = '{-32'sd9320634, -32'sd1274,     1'b1, 32'sd7316,       -32'sd50,       1'b0};
        vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000,   32'd0,          1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF,   32'd0,          1'b0};
        vecs[12] = '{32'd7,         32'hFFFF_FFFF,  1'b0, 32'd0,           32'd7,          1'b0};
        vecs[13] = '{-32'sd5,       32'd0,          1'b1, 32'hFFFF_FFFF,   32'hFFFF_FFFB,  1'b1};
        vecs[14] = '{32'sd7,        -32'sd2,        1'b1, -32'sd3,         32'd1,          1'b0};
        vecs[15] = '{-32'sd7,       32'sd2,         1'b1, -32'sd3,         -32'sd1,        1'b0};
        vecs[16] = '{32'h8000_0000, 32'd7,          1'b0, 32'd306783378,   32'd2,          1'b0};
        vecs[17] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b1, 32'd1,           32'd0,          1'b0};
        vecs[18] = '{32'h8000_0000, 32'h8000_0000,  1'b1, 32'd1,           32'd0,          1'b0};

        // Reset state
        #1;
        chk("rst_quotient",  quotient,  32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_error",     {31'd0, error}, 32'd0);
        chk("rst_busy",      {31'd0, busy},  32'd0);
        chk("rst_done",      {31'd0, done},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table, issued back-to-back
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sg, -1, q, r, e, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd33);
            chk($sformatf("v%0d_q", i), q, vecs[i].q);
            chk($sformatf("v%0d_r", i), r, vecs[i].r);
            chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].e});
        end

        // start pulsed while busy must be ignored
        run_op(32'd183, 32'd14, 1'b0, 5, q, r, e, lat);
        chk("busy_poke_latency", lat, 32'd33);
        chk("busy_poke_q", q, 32'd13);
        chk("busy_poke_r", r, 32'd1);

        // start pulsed in FIN must be ignored
        run_op(32'd1003, 32'd150, 1'b0, 32, q, r, e, lat);
        chk("fin_poke_latency", lat, 32'd33);
        chk("fin_poke_q", q, 32'd6);
        @(posedge clk);
        #1;
        chk("fin_poke_not_started", {31'd0, busy}, 32'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        dividend = 32'd467;
        divider  = 32'd13;
        s        = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_quotient",  quotient,  32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        chk("midrst_busy",      {31'd0, busy}, 32'd0);
        done_seen = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_seen++;
            end
        end
        chk("midrst_no_done", done_seen, 32'd0);
        run_op(32'd1000, 32'd100, 1'b0, -1, q, r, e, lat);
        chk("postrst_latency", lat, 32'd33);
        chk("postrst_q", q, 32'd10);
        chk("postrst_r", r, 32'd0);

        // Random operands against the reference model
        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            rs = n[0];
            if ($urandom_range(0, 3) == 0) begin
                rb = $urandom_range(0, 20);
            end else if ($urandom_range(0, 3) == 0) begin
                rb = $urandom & 32'h0000_FFFF;
            end else begin
                rb = $urandom;
            end
            ref_div(ra, rb, rs, eq, er, ee);
            run_op(ra, rb, rs, -1, q, r, e, lat);
            chk($sformatf("rnd%0d_latency", n), lat, 32'd33);
            chk($sformatf("rnd%0d_q a=%h b=%h s=%0d", n, ra, rb, rs), q, eq);
            chk($sformatf("rnd%0d_r a=%h b=%h s=%0d", n, ra, rb, rs), r, er);
            chk($sformatf("rnd%0d_err", n), {31'd0, e}, {31'd0, ee});
            if (rb != 32'd0) begin
                chk($sformatf("rnd%0d_identity", n), q * rb + r, ra);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
